// File: rtl/obstacle_checker_multi.sv
// Game-state checker: tests the bird box against NUM_PIPES pipes and the floor every cycle,
// runs the INITIAL/CHECK/LOSE game FSM and keeps a saturating Score and High_Score.
module obstacle_checker_multi #(
    parameter int NUM_PIPES = 4,
    parameter int COORD_W   = 10,
    parameter int PIPE_W    = 80,
    parameter int GAP_H     = 100,
    parameter int BIRD_W    = 16,
    parameter int BIRD_H    = 16,
    parameter int FLOOR_Y   = 479,
    parameter int SCORE_W   = 8
) (
    input  logic                           Clk,
    input  logic                           reset,
    input  logic                           Start,
    input  logic                           Ack,
    input  logic [COORD_W-1:0]             Bird_X,
    input  logic [COORD_W-1:0]             Bird_Y,
    input  logic [NUM_PIPES*COORD_W-1:0]   Pipe_X,
    input  logic [NUM_PIPES*COORD_W-1:0]   Gap_Y,
    input  logic [NUM_PIPES-1:0]           Pipe_Valid,
    output logic                           Q_Initial,
    output logic                           Q_Check,
    output logic                           Q_Lose,
    output logic                           Check,
    output logic                           Lose,
    output logic [NUM_PIPES-1:0]           Hit_Vec,
    output logic                           Hit_Floor,
    output logic [SCORE_W-1:0]             Score,
    output logic [SCORE_W-1:0]             High_Score
);

    localparam int EW    = COORD_W + 1;
    localparam int CW    = $clog2(NUM_PIPES + 1);
    localparam int SUM_W = SCORE_W + CW;

    localparam logic [EW-1:0]      FLOOR_LIM = EW'(FLOOR_Y + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        ST_INITIAL = 2'd0,
        ST_CHECK   = 2'd1,
        ST_LOSE    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [EW-1:0]        bird_x;
    logic [EW-1:0]        bird_y;
    logic [EW-1:0]        bird_x2;
    logic [EW-1:0]        bird_y2;
    logic [NUM_PIPES-1:0] hit;
    logic [NUM_PIPES-1:0] pass;
    logic [NUM_PIPES-1:0] passed;
    logic                 floor_hit;
    logic                 any_hit;
    logic [CW-1:0]        new_count;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_next;

    // Edge sums carry one extra bit so a pipe near the right screen edge never wraps.
    assign bird_x  = {1'b0, Bird_X};
    assign bird_y  = {1'b0, Bird_Y};
    assign bird_x2 = bird_x + EW'(BIRD_W);
    assign bird_y2 = bird_y + EW'(BIRD_H);

    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
        logic [EW-1:0] pipe_l;
        logic [EW-1:0] pipe_r;
        logic [EW-1:0] gap_t;
        logic [EW-1:0] gap_b;

        assign pipe_l = {1'b0, Pipe_X[gi*COORD_W +: COORD_W]};
        assign pipe_r = pipe_l + EW'(PIPE_W);
        assign gap_t  = {1'b0, Gap_Y[gi*COORD_W +: COORD_W]};
        assign gap_b  = gap_t + EW'(GAP_H);

        assign hit[gi]  = Pipe_Valid[gi] & (bird_x2 > pipe_l) & (bird_x < pipe_r)
                        & ((bird_y < gap_t) | (bird_y2 > gap_b));
        assign pass[gi] = Pipe_Valid[gi] & (bird_x > (pipe_r - EW'(1)));
    end

    assign floor_hit = bird_y2 > FLOOR_LIM;
    assign any_hit   = (|hit) | floor_hit;

    // A pipe contributes only on the first cycle of its pass.
    always_comb begin
        new_count = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (pass[i] && !passed[i]) begin
                new_count = new_count + CW'(1);
            end
        end
    end

    always_comb begin
        score_sum  = SUM_W'(Score) + SUM_W'(new_count);
        score_next = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= ST_INITIAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_INITIAL;
        case (state)
            ST_INITIAL: state_next = Start   ? ST_CHECK   : ST_INITIAL;
            ST_CHECK:   state_next = any_hit ? ST_LOSE    : ST_CHECK;
            ST_LOSE:    state_next = Ack     ? ST_INITIAL : ST_LOSE;
            default:    state_next = ST_INITIAL;
        endcase
    end

    always_comb begin
        Q_Initial = (state == ST_INITIAL);
        Q_Check   = (state == ST_CHECK);
        Q_Lose    = (state == ST_LOSE);
        Check     = Q_Check;
        Lose      = Q_Lose;
    end

    // On a hit the losing snapshot wins over any pass seen on the same cycle.
    always_ff @(posedge Clk) begin
        if (reset) begin
            Hit_Vec    <= '0;
            Hit_Floor  <= 1'b0;
            Score      <= '0;
            High_Score <= '0;
            passed     <= '0;
        end else begin
            case (state)
                ST_INITIAL: begin
                    if (Start) begin
                        Score     <= '0;
                        passed    <= '0;
                        Hit_Vec   <= '0;
                        Hit_Floor <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (any_hit) begin
                        Hit_Vec   <= hit;
                        Hit_Floor <= floor_hit;
                        if (Score > High_Score) begin
                            High_Score <= Score;
                        end
                    end else begin
                        passed <= pass;
                        Score  <= score_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_checker_multi.sv
// Self-checking bench for obstacle_checker_multi: directed game scenarios plus random play,
// all compared against a geometric reference model of the game rules.
module tb_obstacle_checker_multi;

    localparam int NP = 4;
    localparam int CWD = 10;

    logic              Clk;
    logic              reset;
    logic              Start;
    logic              Ack;
    logic [CWD-1:0]    Bird_X;
    logic [CWD-1:0]    Bird_Y;
    logic [NP*CWD-1:0] Pipe_X;
    logic [NP*CWD-1:0] Gap_Y;
    logic [NP-1:0]     Pipe_Valid;
    logic              Q_Initial;
    logic              Q_Check;
    logic              Q_Lose;
    logic              Check;
    logic              Lose;
    logic [NP-1:0]     Hit_Vec;
    logic              Hit_Floor;
    logic [7:0]        Score;
    logic [7:0]        High_Score;

    int                test_count = 0;
    int                fail_count = 0;

    logic [CWD-1:0]    px[NP];
    logic [CWD-1:0]    gy[NP];

    // Reference model state: 0 = waiting, 1 = playing, 2 = lost.
    int                m_phase;
    int                m_score;
    int                m_high;
    int                m_hit_vec;
    int                m_hit_floor;
    bit                m_passed[NP];

    obstacle_checker_multi dut (
        .Clk        (Clk),
        .reset      (reset),
        .Start      (Start),
        .Ack        (Ack),
        .Bird_X     (Bird_X),
        .Bird_Y     (Bird_Y),
        .Pipe_X     (Pipe_X),
        .Gap_Y      (Gap_Y),
        .Pipe_Valid (Pipe_Valid),
        .Q_Initial  (Q_Initial),
        .Q_Check    (Q_Check),
        .Q_Lose     (Q_Lose),
        .Check      (Check),
        .Lose       (Lose),
        .Hit_Vec    (Hit_Vec),
        .Hit_Floor  (Hit_Floor),
        .Score      (Score),
        .High_Score (High_Score)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    for (genvar gi = 0; gi < NP; gi++) begin : g_pack
        assign Pipe_X[gi*CWD +: CWD] = px[gi];
        assign Gap_Y[gi*CWD +: CWD]  = gy[gi];
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Game rules written directly as screen geometry in plain integers.
    task automatic model_update();
        int  bx;
        int  by;
        int  hits;
        int  fresh;
        bit  on_floor;
        bit  passing[NP];
        bx = int'(Bird_X);
        by = int'(Bird_Y);
        hits = 0;
        fresh = 0;
        on_floor = (by + 16) > 480;
        for (int i = 0; i < NP; i++) begin
            int  left;
            int  top;
            bit  overlap_x;
            bit  outside_gap;
            left = int'(px[i]);
            top  = int'(gy[i]);
            overlap_x   = (bx + 16 > left) && (bx < left + 80);
            outside_gap = (by < top) || (by + 16 > top + 100);
            if (Pipe_Valid[i] && overlap_x && outside_gap) hits |= (1 << i);
            passing[i] = Pipe_Valid[i] && (bx >= left + 80);
        end
        if (reset) begin
            m_phase = 0; m_score = 0; m_high = 0; m_hit_vec = 0; m_hit_floor = 0;
            for (int i = 0; i < NP; i++) m_passed[i] = 1'b0;
        end else if (m_phase == 0) begin
            if (Start) begin
                m_phase = 1; m_score = 0; m_hit_vec = 0; m_hit_floor = 0;
                for (int i = 0; i < NP; i++) m_passed[i] = 1'b0;
            end
        end else if (m_phase == 1) begin
            if (hits != 0 || on_floor) begin
                m_phase = 2;
                m_hit_vec = hits;
                m_hit_floor = on_floor;
                if (m_score > m_high) m_high = m_score;
            end else begin
                for (int i = 0; i < NP; i++) begin
                    if (passing[i] && !m_passed[i]) fresh++;
                    m_passed[i] = passing[i];
                end
                m_score = (m_score + fresh > 255) ? 255 : m_score + fresh;
            end
        end else if (Ack) begin
            m_phase = 0;
        end
    endtask

    task automatic compare_model();
        check_output("q_initial",  Q_Initial,  m_phase == 0);
        check_output("q_check",    Q_Check,    m_phase == 1);
        check_output("q_lose",     Q_Lose,     m_phase == 2);
        check_output("check_out",  Check,      m_phase == 1);
        check_output("lose_out",   Lose,       m_phase == 2);
        check_output("hit_vec",    Hit_Vec,    m_hit_vec);
        check_output("hit_floor",  Hit_Floor,  m_hit_floor);
        check_output("score",      Score,      m_score);
        check_output("high_score", High_Score, m_high);
    endtask

    task automatic apply_stimulus(input bit rst, input bit st, input bit ak);
        reset = rst;
        Start = st;
        Ack   = ak;
        @(posedge Clk);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic set_pipe(input int i, input bit valid, input int x, input int g);
        Pipe_Valid[i] = valid;
        px[i] = CWD'(x);
        gy[i] = CWD'(g);
    endtask

    task automatic set_bird(input int x, input int y);
        Bird_X = CWD'(x);
        Bird_Y = CWD'(y);
    endtask

    task automatic clear_pipes();
        for (int i = 0; i < NP; i++) set_pipe(i, 1'b0, 600, 150);
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; Ack = 1'b0;
        set_bird(100, 200);
        clear_pipes();
        m_phase = 0; m_score = 0; m_high = 0; m_hit_vec = 0; m_hit_floor = 0;
        for (int i = 0; i < NP; i++) m_passed[i] = 1'b0;

        apply_stimulus(1, 0, 0);
        apply_stimulus(1, 0, 0);
        check_output("reset_initial", Q_Initial, 1);
        apply_stimulus(0, 1, 0);
        check_output("start_check", Q_Check, 1);
        check_output("start_score", Score, 0);

        // Single pipe collision and touching-edge cases.
        set_pipe(0, 1'b1, 90, 150);
        apply_stimulus(0, 0, 0);
        check_output("gap_clear", Q_Check, 1);
        set_pipe(0, 1'b1, 90, 210);
        apply_stimulus(0, 0, 0);
        check_output("pipe_lose", Q_Lose, 1);
        check_output("pipe_hitvec", Hit_Vec, 4'b0001);
        apply_stimulus(0, 1, 0);
        check_output("lose_ignores_start", Q_Lose, 1);
        apply_stimulus(0, 0, 1);
        check_output("ack_initial", Q_Initial, 1);
        set_bird(100, 150);
        set_pipe(0, 1'b1, 90, 150);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 0, 0);
        check_output("touch_top", Q_Check, 1);

        // Scoring: right edge boundary, hold, recycle, and simultaneous passes.
        set_bird(100, 200);
        set_pipe(0, 1'b1, 21, 150);
        apply_stimulus(0, 0, 0);
        check_output("edge_no_pass", Score, 0);
        set_pipe(0, 1'b1, 20, 150);
        repeat (5) apply_stimulus(0, 0, 0);
        check_output("pass_once", Score, 1);
        set_pipe(0, 1'b1, 600, 150);
        apply_stimulus(0, 0, 0);
        set_pipe(0, 1'b1, 20, 150);
        apply_stimulus(0, 0, 0);
        check_output("recycle_pass", Score, 2);
        set_pipe(1, 1'b1, 10, 150);
        set_pipe(2, 1'b1, 10, 150);
        apply_stimulus(0, 0, 0);
        check_output("double_pass", Score, 4);

        // Floor boundary.
        clear_pipes();
        set_bird(100, 464);
        apply_stimulus(0, 0, 0);
        check_output("floor_touch", Q_Check, 1);
        set_bird(100, 465);
        apply_stimulus(0, 0, 0);
        check_output("floor_lose", Q_Lose, 1);
        check_output("floor_flag", Hit_Floor, 1);
        check_output("floor_high", High_Score, 4);
        apply_stimulus(0, 0, 1);
        set_bird(100, 200);
        apply_stimulus(0, 1, 0);
        check_output("restart_score", Score, 0);

        // Saturation of the score counter.
        for (int k = 0; k < 70; k++) begin
            for (int i = 0; i < NP; i++) set_pipe(i, 1'b1, 600, 150);
            apply_stimulus(0, 0, 0);
            for (int i = 0; i < NP; i++) set_pipe(i, 1'b1, 10, 150);
            apply_stimulus(0, 0, 0);
        end
        check_output("score_sat", Score, 255);
        clear_pipes();
        set_bird(100, 470);
        apply_stimulus(0, 0, 0);
        check_output("high_sat", High_Score, 255);
        apply_stimulus(0, 0, 1);
        set_bird(100, 200);
        apply_stimulus(0, 1, 0);
        set_pipe(0, 1'b1, 20, 150);
        apply_stimulus(0, 0, 0);
        set_bird(100, 470);
        apply_stimulus(0, 0, 0);
        check_output("high_kept", High_Score, 255);

        // Reset in the middle of a game.
        apply_stimulus(0, 0, 1);
        set_bird(100, 200);
        apply_stimulus(0, 1, 0);
        set_pipe(0, 1'b1, 20, 150);
        apply_stimulus(0, 0, 0);
        set_pipe(0, 1'b1, 600, 150);
        apply_stimulus(0, 0, 0);
        set_pipe(0, 1'b1, 20, 150);
        apply_stimulus(0, 0, 0);
        check_output("mid_score", Score, 2);
        apply_stimulus(1, 0, 0);
        check_output("mid_reset_state", Q_Initial, 1);
        check_output("mid_reset_high", High_Score, 0);

        // Random play.
        for (int n = 0; n < 3000; n++) begin
            set_bird(int'($urandom_range(0, 300)), int'($urandom_range(0, 470)));
            for (int i = 0; i < NP; i++) begin
                set_pipe(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 700)),
                         int'($urandom_range(0, 380)));
            end
            apply_stimulus($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
                           $urandom_range(0, 9) < 3);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
